ula_op_dispatch: RTL
====================

Name: ula_op_dispatch

Overview:
- Issue side of the ULA datapath. Accepts one operation request (opcode plus two operands) through a valid/ready handshake.
- Pulses a one-hot start strobe to the addressed functional unit and drives the 3-bit Selector that steers the 8-to-1 result multiplexer.
- Waits for that unit's done flag, registers the multiplexed result, and returns it through a response valid/ready handshake.
- Rejects reserved and illegal operations without issuing them.

Parameters:
- WIDTH, 4: operand width in bits.
- TIMEOUT, 15: maximum cycles spent in WAIT before the operation is aborted with an error.

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  synchronous reset, active-low
- ReqValid  in  1  request present
- ReqReady  out  1  dispatcher can accept a request
- ReqOp  in  3  opcode: 0 NotUse, 1 Add, 2 Sub, 3 Mul, 4 Div, 5 And, 6 Or, 7 Xor
- ReqA  in  WIDTH  operand A
- ReqB  in  WIDTH  operand B
- Start  out  8  one-hot, single-cycle start strobe; bit index = opcode
- OpA  out  WIDTH  registered operand A to all units
- OpB  out  WIDTH  registered operand B to all units
- Selector  out  3  result-mux select, held from ISSUE through RESP
- UnitDone  in  8  per-unit done flags; bit index = opcode
- MuxY  in  2*WIDTH  result returned by the result multiplexer
- RespValid  out  1  response present
- RespReady  in  1  consumer accepts the response
- RespResult  out  2*WIDTH  captured result
- RespErr  out  1  1 = reserved op, divide by zero, or timeout

Behaviour:
- Reset (Reset_n=0 at a clock edge), including mid-operation:
  - state = IDLE; Start, RespValid, RespErr, RespResult, OpA, OpB, Selector and the timeout counter all cleared to 0.
  - No pending operation survives reset.
- ReqReady = 1 only in IDLE. It is combinational from state, not from ReqValid.
- IDLE: on ReqValid & ReqReady, latch ReqOp into Selector, ReqA into OpA, ReqB into OpB.
  - ReqOp == 0 (NotUse) -> RESP with RespErr=1, RespResult=0. No Start.
  - ReqOp == 4 and ReqB == 0 -> RESP with RespErr=1, RespResult=0. No Start.
  - Otherwise -> ISSUE.
- ISSUE (exactly one cycle): Start[Selector] = 1, all other Start bits 0. Clear the timeout counter. -> WAIT.
- WAIT:
  - Only UnitDone[Selector] is sampled. All other UnitDone bits are ignored.
  - A done flag asserted during the ISSUE cycle is not sampled.
  - When UnitDone[Selector] = 1: capture MuxY into RespResult, RespErr=0, -> RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: RespErr=1, RespResult=0, -> RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: RespValid=1. RespResult, RespErr and Selector stay stable until RespReady=1. On the accepting edge, RespValid drops and state -> IDLE.
  - ReqReady stays 0 throughout RESP; there is no request/response overlap.
  - Back-to-back throughput: a new request can be accepted the cycle after the response is accepted.
- Latency for a legal op accepted at edge N:
  - Start high in cycle N+1.
  - Earliest done sampled in cycle N+2.
  - RespValid from cycle N+3.
- Rejected-op latency: RespValid in the cycle after acceptance.
- Width rules:
  - MuxY is 2*WIDTH so the Mul product is full width. The dispatcher never modifies it.
  - Narrower unit results are zero-extended by the datapath, not by this block.
- Start is registered with no glitches. It is never asserted outside ISSUE and never on more than one bit.

Decomposition:
- Shared package ula_pkg:
  - Opcode localparams: OP_NOTUSE=0 … OP_XOR=7.
  - 2-bit state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Default WIDTH and TIMEOUT.
- One sub-module, decoder3to8: 3-bit select plus enable in, one-hot 8-bit out; generates Start from Selector.
- FSM, counter and registers stay in ula_op_dispatch.

Test Plan:
- WIDTH=4, Add, A=3, B=5; UnitDone[1] pulsed 2 cycles after Start, MuxY=8'h08 -> Start=8'b0000_0010 for exactly one cycle, Selector=1, RespValid with RespResult=8'h08, RespErr=0.
- Mul, A=15, B=15; done after 4 cycles, MuxY=8'hE1; RespReady held low for 3 cycles -> RespResult stays 8'hE1, RespValid stays high and ReqReady stays 0 until accepted, then back to IDLE.
- Div with B=0, and separately ReqOp=0 -> no Start bit ever set; RespValid the next cycle with RespErr=1, RespResult=0.
- Xor issued; UnitDone[7] never asserted while UnitDone[3] toggles -> the stray done is ignored; after 15 WAIT cycles RespErr=1, RespResult=0.
- Reset_n driven low for one cycle during WAIT of a Sub -> next cycle all outputs 0, ReqReady=1; a later done pulse produces no response.
- Two back-to-back requests (And 4'hC & 4'hA, then Or) with RespReady tied high -> responses 8'h08 then the Or result, in order, with a second Start pulse only after the first response is accepted.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA issue path: opcodes, FSM encoding, defaults.
package ula_pkg;

  localparam logic [2:0] OP_NOTUSE = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_AND    = 3'd5;
  localparam logic [2:0] OP_OR     = 3'd6;
  localparam logic [2:0] OP_XOR    = 3'd7;

  localparam int unsigned WIDTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Ops that are answered with an error instead of being issued to a unit.
  function automatic logic op_rejected(input logic [2:0] op, input logic b_zero);
    logic rej;
    rej = 1'b0;
    case (op)
      OP_NOTUSE: rej = 1'b1;
      OP_DIV:    rej = b_zero;
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: rej = 1'b0;
      default:   rej = 1'b0;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable; produces the unit start strobe pattern.
module decoder3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_onehot
);

  // All zeros unless enabled, then exactly the selected bit.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/ula_op_dispatch.sv
// ULA issue-side dispatcher: accepts an op, strobes its unit, waits for done
// (or timeout) and hands the muxed result back through a response handshake.
module ula_op_dispatch
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [2:0]         ReqOp,
  input  logic [WIDTH-1:0]   ReqA,
  input  logic [WIDTH-1:0]   ReqB,
  output logic [7:0]         Start,
  output logic [WIDTH-1:0]   OpA,
  output logic [WIDTH-1:0]   OpB,
  output logic [2:0]         Selector,
  input  logic [7:0]         UnitDone,
  input  logic [2*WIDTH-1:0] MuxY,
  output logic               RespValid,
  input  logic               RespReady,
  output logic [2*WIDTH-1:0] RespResult,
  output logic               RespErr
);

  localparam int unsigned     CntW       = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  state_e               r_state, w_state_d;
  logic [2:0]           r_sel, w_sel_d;
  logic [WIDTH-1:0]     r_opa, w_opa_d;
  logic [WIDTH-1:0]     r_opb, w_opb_d;
  logic [7:0]           r_start, w_start_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d, w_cnt_inc;
  logic [2*WIDTH-1:0]   r_result, w_result_d;
  logic                 r_err, w_err_d;

  // Start is decoded from next-state values and registered, so it is glitch-free
  // and high exactly while the FSM sits in ISSUE.
  decoder3to8 u_start_dec (
    .i_sel    (w_sel_d),
    .i_en     (w_state_d == StIssue),
    .o_onehot (w_start_d)
  );

  // Next-state logic: handshake, reject, issue, wait/timeout, response hold.
  always_comb begin
    w_state_d  = r_state;
    w_sel_d    = r_sel;
    w_opa_d    = r_opa;
    w_opb_d    = r_opb;
    w_cnt_d    = r_cnt;
    w_result_d = r_result;
    w_err_d    = r_err;
    w_cnt_inc  = r_cnt + 1'b1;
    case (r_state)
      StIdle: begin
        if (ReqValid) begin
          w_sel_d = ReqOp;
          w_opa_d = ReqA;
          w_opb_d = ReqB;
          if (op_rejected(ReqOp, ReqB == '0)) begin
            w_err_d    = 1'b1;
            w_result_d = '0;
            w_state_d  = StResp;
          end else begin
            w_state_d = StIssue;
          end
        end
      end
      StIssue: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        // Done has priority over a timeout landing in the same cycle.
        if (UnitDone[r_sel]) begin
          w_result_d = MuxY;
          w_err_d    = 1'b0;
          w_state_d  = StResp;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == TimeoutCnt) begin
            w_result_d = '0;
            w_err_d    = 1'b1;
            w_state_d  = StResp;
          end
        end
      end
      StResp: begin
        if (RespReady) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state  <= StIdle;
      r_sel    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_start  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_sel    <= w_sel_d;
      r_opa    <= w_opa_d;
      r_opb    <= w_opb_d;
      r_start  <= w_start_d;
      r_cnt    <= w_cnt_d;
      r_result <= w_result_d;
      r_err    <= w_err_d;
    end
  end

  assign ReqReady   = (r_state == StIdle);
  assign RespValid  = (r_state == StResp);
  assign Start      = r_start;
  assign OpA        = r_opa;
  assign OpB        = r_opb;
  assign Selector   = r_sel;
  assign RespResult = r_result;
  assign RespErr    = r_err;

endmodule
